int_trap_csr: RTL and testbench
===============================

Name: int_trap_csr

Overview:
- Core-side responder for the interrupt controller's strobe/cause/done protocol.
- Holds the machine trap CSRs: mie, mtvec, mscratch, mepc and mcause.
- Accepts an interrupt strobe plus cause, saves the PC and cause, and redirects fetch to mtvec.
- On mret, returns fetch to mepc and pulses the interrupt-done line back to the controller.

Parameters:
- MTVEC_RST, 32'h0000_0000, reset value of mtvec.
- MIE_RST, 32'h0000_0000, reset value of mie; all sources masked by default.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- csr_op_i  in  2  CSR operation: 0 none, 1 RW (write), 2 RS (set bits), 3 RC (clear bits).
- csr_addr_i  in  12  CSR address.
- csr_wd_i  in  32  CSR operand.
- csr_rd_o  out  32  old value of the addressed CSR, combinational; 0 for an unknown address.
- csr_pc_i  in  32  PC of the instruction being interrupted.
- csr_mret_i  in  1  mret is executing this cycle.
- csr_int_i  in  1  interrupt strobe from the controller.
- csr_mcause_i  in  32  cause ID from the controller; valid while csr_int_i is high.
- csr_mie_o  out  32  mie, drives the controller's mask input.
- csr_mtvec_o  out  32  trap vector.
- csr_mepc_o  out  32  return PC.
- csr_trap_o  out  1  fetch redirect to mtvec, combinational.
- csr_int_rst_o  out  1  interrupt-done pulse to the controller, registered.

Behaviour:
- Address map:
  - mie 0x304
  - mtvec 0x305
  - mscratch 0x340
  - mepc 0x341
  - mcause 0x342
  - Any other address: reads 0, writes dropped.
- Write value by operation:
  - RW: new = wd.
  - RS: new = old | wd.
  - RC: new = old & ~wd.
  - Written at the clock edge; op 0 performs no write.
- Reset (async):
  - mie = MIE_RST, mtvec = MTVEC_RST.
  - mscratch, mepc, mcause = 0.
  - FSM = IDLE; csr_int_rst_o = 0; csr_trap_o = 0.
- FSM states: IDLE, HANDLER, ACK.
  - IDLE:
    - csr_trap_o = csr_int_i (combinational, same cycle as the strobe).
    - When csr_int_i is high, at the edge: mepc <= csr_pc_i, mcause <= csr_mcause_i, next state HANDLER.
    - csr_mret_i is ignored in IDLE: no pulse, no state change.
  - HANDLER:
    - csr_int_i is ignored (no nesting); csr_trap_o = 0.
    - When csr_mret_i is high: next state ACK, csr_int_rst_o <= 1.
  - ACK:
    - Exactly one cycle; csr_int_rst_o is high throughout.
    - csr_int_i is ignored, so a stale strobe cannot re-trap.
    - At the edge: csr_int_rst_o <= 0, next state IDLE.
- Trap capture vs. CSR write to the same register in the same cycle: trap capture of mepc/mcause wins, and the CSR write to that register is lost. Writes to other CSRs in that cycle proceed.
- csr_rd_o always returns the pre-edge value, never a write-through.
- mie takes effect toward the controller on the cycle after the write edge.
- mepc/mcause writes during HANDLER are allowed; mret uses the updated csr_mepc_o.
- Reset asserted in HANDLER or ACK:
  - Immediate return to IDLE.
  - No csr_int_rst_o pulse is issued.
  - The controller is expected to be reset by the same line.
- Latency:
  - Strobe to redirect: 0 cycles.
  - Strobe to mepc/mcause visible: 1 edge.
  - mret to csr_int_rst_o high: 1 edge, width 1 cycle.
  - Minimum IDLE re-entry after mret: 2 edges.

Decomposition:
- Shared package int_csr_pkg holds:
  - CSR address constants (CSR_MIE, CSR_MTVEC, CSR_MSCRATCH, CSR_MEPC, CSR_MCAUSE).
  - Operation codes (CSR_OP_NONE, CSR_OP_RW, CSR_OP_RS, CSR_OP_RC).
  - FSM state encoding (ST_IDLE, ST_HANDLER, ST_ACK).
- One sub-module, csr_op_unit: combinational (old, wd, op) -> new value. It is reused by the future full CSR file.

Test Plan:
1. Reset, then read all five addresses -> csr_rd_o = 0 for each; csr_mie_o = 0; csr_int_rst_o = 0.
2. RW 0x305 with 0x0000_0100, then RS 0x304 with 0x5, then RC 0x304 with 0x1 -> csr_mtvec_o = 0x100, csr_mie_o = 0x4; a read of 0x123 returns 0.
3. In IDLE, csr_int_i = 1, csr_mcause_i = 7, csr_pc_i = 0x40 -> csr_trap_o = 1 in the same cycle. Next cycle: mepc = 0x40, mcause = 7, state HANDLER.
4. In HANDLER, hold csr_int_i = 1 for 3 cycles -> csr_trap_o stays 0, mepc stays 0x40. Then csr_mret_i = 1 -> csr_int_rst_o high for exactly 1 cycle (ACK), then IDLE.
5. Trap and RW 0x341 with 0xDEAD in the same cycle -> mepc = csr_pc_i, not 0xDEAD. Separately, mret in IDLE -> no csr_int_rst_o pulse.
6. Assert reset asynchronously mid-HANDLER -> outputs clear without waiting for a clock edge. After release: state IDLE, csr_int_rst_o never pulsed, csr_mie_o = MIE_RST.

Source files
------------

// File: rtl/int_csr_pkg.sv
// Shared definitions for the machine trap CSR block: CSR addresses,
// operation codes and trap FSM state encoding.
package int_csr_pkg;

  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;

  typedef enum logic [1:0] {
    CSR_OP_NONE = 2'd0,
    CSR_OP_RW   = 2'd1,
    CSR_OP_RS   = 2'd2,
    CSR_OP_RC   = 2'd3
  } csr_op_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HANDLER = 2'd1,
    ST_ACK     = 2'd2
  } state_t;

endpackage

// File: rtl/int_trap_csr_if.sv
// Core-side CSR access port plus the interrupt controller strobe/cause/done
// handshake. csr_state_o exposes the trap FSM for observation.
//
// Handshake: csr_int_i is a level strobe sampled in IDLE only; the core answers
// with csr_trap_o in the same cycle, and after mret in HANDLER it raises
// csr_int_rst_o for exactly one cycle. No backpressure exists on either side.
interface int_trap_csr_if;
  import int_csr_pkg::*;

  logic [1:0]  csr_op_i;
  logic [11:0] csr_addr_i;
  logic [31:0] csr_wd_i;
  logic [31:0] csr_rd_o;
  logic [31:0] csr_pc_i;
  logic        csr_mret_i;
  logic        csr_int_i;
  logic [31:0] csr_mcause_i;
  logic [31:0] csr_mie_o;
  logic [31:0] csr_mtvec_o;
  logic [31:0] csr_mepc_o;
  logic        csr_trap_o;
  logic        csr_int_rst_o;
  state_t      csr_state_o;

  modport slave (
    input  csr_op_i, csr_addr_i, csr_wd_i, csr_pc_i, csr_mret_i,
           csr_int_i, csr_mcause_i,
    output csr_rd_o, csr_mie_o, csr_mtvec_o, csr_mepc_o, csr_trap_o,
           csr_int_rst_o, csr_state_o
  );

  modport master (
    output csr_op_i, csr_addr_i, csr_wd_i, csr_pc_i, csr_mret_i,
           csr_int_i, csr_mcause_i,
    input  csr_rd_o, csr_mie_o, csr_mtvec_o, csr_mepc_o, csr_trap_o,
           csr_int_rst_o, csr_state_o
  );

endinterface

// File: rtl/csr_op_unit.sv
// Combinational CSR read-modify-write: computes the new register value
// from the old value, the operand and the operation.
module csr_op_unit
  import int_csr_pkg::*;
(
  input  logic [31:0] old_val,
  input  logic [31:0] wd,
  input  csr_op_t     op,
  output logic [31:0] new_val
);

  always_comb begin
    new_val = old_val;
    case (op)
      CSR_OP_RW: new_val = wd;
      CSR_OP_RS: new_val = old_val | wd;
      CSR_OP_RC: new_val = old_val & ~wd;
      default:   new_val = old_val;
    endcase
  end

endmodule

// File: rtl/int_trap_csr.sv
// Machine trap CSRs and the interrupt entry/return sequencer that answers
// the interrupt controller's strobe/cause/done protocol.
module int_trap_csr
  import int_csr_pkg::*;
#(
  parameter logic [31:0] MTVEC_RST = 32'h0000_0000,
  parameter logic [31:0] MIE_RST   = 32'h0000_0000
) (
  input  logic           clk,
  input  logic           reset,
  int_trap_csr_if.slave  bus
);

  logic [31:0] mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q;
  logic [31:0] rd_val, wr_val;
  logic        addr_hit, wr_en;
  logic        trap_c, take_trap, ack_set, int_rst_q;
  csr_op_t     op;
  state_t      state_q, state_d;

  assign op = csr_op_t'(bus.csr_op_i);

  always_comb begin
    rd_val   = 32'h0;
    addr_hit = 1'b1;
    case (bus.csr_addr_i)
      CSR_MIE:      rd_val = mie_q;
      CSR_MTVEC:    rd_val = mtvec_q;
      CSR_MSCRATCH: rd_val = mscratch_q;
      CSR_MEPC:     rd_val = mepc_q;
      CSR_MCAUSE:   rd_val = mcause_q;
      default:      addr_hit = 1'b0;
    endcase
  end

  assign wr_en = (op != CSR_OP_NONE) && addr_hit;

  csr_op_unit u_op (
    .old_val (rd_val),
    .wd      (bus.csr_wd_i),
    .op      (op),
    .new_val (wr_val)
  );

  // Trap FSM: next state and the per-cycle trap/ack decisions.
  always_comb begin
    state_d   = state_q;
    trap_c    = 1'b0;
    take_trap = 1'b0;
    ack_set   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        trap_c = bus.csr_int_i;
        if (bus.csr_int_i) begin
          take_trap = 1'b1;
          state_d   = ST_HANDLER;
        end
      end
      ST_HANDLER: begin
        if (bus.csr_mret_i) begin
          ack_set = 1'b1;
          state_d = ST_ACK;
        end
      end
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      int_rst_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      int_rst_q <= ack_set;
    end
  end

  // Trap capture of mepc/mcause takes priority over a same-cycle CSR write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mie_q      <= MIE_RST;
      mtvec_q    <= MTVEC_RST;
      mscratch_q <= 32'h0;
      mepc_q     <= 32'h0;
      mcause_q   <= 32'h0;
    end else begin
      if (wr_en && bus.csr_addr_i == CSR_MIE)      mie_q      <= wr_val;
      if (wr_en && bus.csr_addr_i == CSR_MTVEC)    mtvec_q    <= wr_val;
      if (wr_en && bus.csr_addr_i == CSR_MSCRATCH) mscratch_q <= wr_val;
      if (take_trap) begin
        mepc_q   <= bus.csr_pc_i;
        mcause_q <= bus.csr_mcause_i;
      end else begin
        if (wr_en && bus.csr_addr_i == CSR_MEPC)   mepc_q     <= wr_val;
        if (wr_en && bus.csr_addr_i == CSR_MCAUSE) mcause_q   <= wr_val;
      end
    end
  end

  assign bus.csr_rd_o      = rd_val;
  assign bus.csr_mie_o     = mie_q;
  assign bus.csr_mtvec_o   = mtvec_q;
  assign bus.csr_mepc_o    = mepc_q;
  assign bus.csr_trap_o    = trap_c & ~reset;
  assign bus.csr_int_rst_o = int_rst_q;
  assign bus.csr_state_o   = state_q;

endmodule

// File: tb/tb_int_trap_csr.sv
// Bench for int_trap_csr: table of single-cycle vectors with post-edge
// expectations queued in a scoreboard, plus random mscratch ops and an async reset sequence.
module tb_int_trap_csr;
  import int_csr_pkg::*;

  localparam int W = 99;
  localparam logic [31:0] MIE_RST   = 32'h0;
  localparam logic [31:0] MTVEC_RST = 32'h0;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int_trap_csr_if bus ();

  int_trap_csr #(.MTVEC_RST(MTVEC_RST), .MIE_RST(MIE_RST)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [1:0]  op;
    logic [11:0] addr;
    logic [31:0] wd;
    logic [31:0] pc;
    logic        mret;
    logic        intr;
    logic [31:0] cause;
    logic [31:0] exp_rd;
    logic        exp_trap;
    logic [31:0] exp_mie;
    logic [31:0] exp_mtvec;
    logic [31:0] exp_mepc;
    logic        exp_irst;
    state_t      exp_st;
  } vec_t;

  vec_t           vecs[$];
  logic [W-1:0]   exp_q[$];
  int             n_vec = 0;
  int             n_bad = 0;

  function automatic vec_t mk(input logic [1:0] op, input logic [11:0] addr,
                              input logic [31:0] wd, input logic [31:0] pc,
                              input logic mret, input logic intr,
                              input logic [31:0] cause, input logic [31:0] exp_rd,
                              input logic exp_trap, input logic [31:0] exp_mie,
                              input logic [31:0] exp_mtvec, input logic [31:0] exp_mepc,
                              input logic exp_irst, input state_t exp_st);
    vec_t v;
    v.op = op; v.addr = addr; v.wd = wd; v.pc = pc; v.mret = mret;
    v.intr = intr; v.cause = cause; v.exp_rd = exp_rd; v.exp_trap = exp_trap;
    v.exp_mie = exp_mie; v.exp_mtvec = exp_mtvec; v.exp_mepc = exp_mepc;
    v.exp_irst = exp_irst; v.exp_st = exp_st;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wd,
                       input logic [31:0] pc, input logic mret, input logic intr,
                       input logic [31:0] cause);
    bus.csr_op_i     = op;
    bus.csr_addr_i   = addr;
    bus.csr_wd_i     = wd;
    bus.csr_pc_i     = pc;
    bus.csr_mret_i   = mret;
    bus.csr_int_i    = intr;
    bus.csr_mcause_i = cause;
  endtask

  // Drive one vector mid-cycle, check combinational outputs before the edge,
  // queue the post-edge expectation and compare it after the edge.
  task automatic apply(input vec_t v, input int idx);
    logic [W-1:0] e;
    @(negedge clk);
    drive(v.op, v.addr, v.wd, v.pc, v.mret, v.intr, v.cause);
    #1;
    chk($sformatf("v%0d rd", idx), bus.csr_rd_o, v.exp_rd);
    chk($sformatf("v%0d trap", idx), 32'(bus.csr_trap_o), 32'(v.exp_trap));
    exp_q.push_back({v.exp_mie, v.exp_mtvec, v.exp_mepc, v.exp_irst, v.exp_st});
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      n_vec++; n_bad++;
      $display("FAIL v%0d scoreboard empty: got 0 entries expected 1", idx);
    end else begin
      e = exp_q.pop_front();
      chk($sformatf("v%0d mie", idx),   bus.csr_mie_o,   e[98:67]);
      chk($sformatf("v%0d mtvec", idx), bus.csr_mtvec_o, e[66:35]);
      chk($sformatf("v%0d mepc", idx),  bus.csr_mepc_o,  e[34:3]);
      chk($sformatf("v%0d int_rst", idx), 32'(bus.csr_int_rst_o), 32'(e[2]));
      chk($sformatf("v%0d state", idx), 32'(bus.csr_state_o), 32'(e[1:0]));
    end
  endtask

  initial begin
    logic [31:0] ms;
    logic [31:0] wd;
    logic [1:0]  op;
    logic [31:0] nxt;
    int          pulses;

    // Test plan vectors: op, addr, wd, pc, mret, int, cause | rd, trap | mie, mtvec, mepc, irst, state
    vecs.push_back(mk(2'd0, 12'h304, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, ST_IDLE));
    vecs.push_back(mk(2'd0, 12'h305, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, ST_IDLE));
    vecs.push_back(mk(2'd0, 12'h340, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, ST_IDLE));
    vecs.push_back(mk(2'd0, 12'h341, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, ST_IDLE));
    vecs.push_back(mk(2'd0, 12'h342, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, ST_IDLE));
    vecs.push_back(mk(2'd1, 12'h305, 32'h100, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h100, 32'h0, 1'b0, ST_IDLE));
    vecs.push_back(mk(2'd2, 12'h304, 32'h5, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h5, 32'h100, 32'h0, 1'b0, ST_IDLE));
    vecs.push_back(mk(2'd3, 12'h304, 32'h1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h5, 1'b0, 32'h4, 32'h100, 32'h0, 1'b0, ST_IDLE));
    vecs.push_back(mk(2'd0, 12'h123, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h4, 32'h100, 32'h0, 1'b0, ST_IDLE));
    vecs.push_back(mk(2'd1, 12'h123, 32'hFFFF, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h4, 32'h100, 32'h0, 1'b0, ST_IDLE));
    vecs.push_back(mk(2'd0, 12'h123, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h4, 32'h100, 32'h0, 1'b0, ST_IDLE));
    vecs.push_back(mk(2'd0, 12'h305, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h100, 1'b0, 32'h4, 32'h100, 32'h0, 1'b0, ST_IDLE));
    vecs.push_back(mk(2'd1, 12'h340, 32'hA5A5, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h4, 32'h100, 32'h0, 1'b0, ST_IDLE));
    vecs.push_back(mk(2'd0, 12'h340, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'hA5A5, 1'b0, 32'h4, 32'h100, 32'h0, 1'b0, ST_IDLE));
    // Trap entry, strobe held in HANDLER, mepc rewrite, mret and ACK.
    vecs.push_back(mk(2'd0, 12'h342, 32'h0, 32'h40, 1'b0, 1'b1, 32'h7, 32'h0, 1'b1, 32'h4, 32'h100, 32'h40, 1'b0, ST_HANDLER));
    vecs.push_back(mk(2'd0, 12'h342, 32'h0, 32'h80, 1'b0, 1'b1, 32'h9, 32'h7, 1'b0, 32'h4, 32'h100, 32'h40, 1'b0, ST_HANDLER));
    vecs.push_back(mk(2'd0, 12'h341, 32'h0, 32'h80, 1'b0, 1'b1, 32'h9, 32'h40, 1'b0, 32'h4, 32'h100, 32'h40, 1'b0, ST_HANDLER));
    vecs.push_back(mk(2'd0, 12'h304, 32'h0, 32'h80, 1'b0, 1'b1, 32'h9, 32'h4, 1'b0, 32'h4, 32'h100, 32'h40, 1'b0, ST_HANDLER));
    vecs.push_back(mk(2'd1, 12'h341, 32'h200, 32'h80, 1'b0, 1'b0, 32'h0, 32'h40, 1'b0, 32'h4, 32'h100, 32'h200, 1'b0, ST_HANDLER));
    vecs.push_back(mk(2'd0, 12'h341, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h200, 1'b0, 32'h4, 32'h100, 32'h200, 1'b1, ST_ACK));
    vecs.push_back(mk(2'd0, 12'h342, 32'h0, 32'h88, 1'b0, 1'b1, 32'h5, 32'h7, 1'b0, 32'h4, 32'h100, 32'h200, 1'b0, ST_IDLE));
    vecs.push_back(mk(2'd0, 12'h342, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h7, 1'b0, 32'h4, 32'h100, 32'h200, 1'b0, ST_IDLE));
    // Trap wins over a same-cycle mepc write; mret in IDLE is ignored.
    vecs.push_back(mk(2'd1, 12'h341, 32'hDEAD, 32'h60, 1'b0, 1'b1, 32'h3, 32'h200, 1'b1, 32'h4, 32'h100, 32'h60, 1'b0, ST_HANDLER));
    vecs.push_back(mk(2'd0, 12'h342, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h3, 1'b0, 32'h4, 32'h100, 32'h60, 1'b0, ST_HANDLER));
    vecs.push_back(mk(2'd0, 12'h000, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h4, 32'h100, 32'h60, 1'b1, ST_ACK));
    vecs.push_back(mk(2'd0, 12'h000, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h4, 32'h100, 32'h60, 1'b0, ST_IDLE));
    vecs.push_back(mk(2'd0, 12'h341, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h60, 1'b0, 32'h4, 32'h100, 32'h60, 1'b0, ST_IDLE));
    vecs.push_back(mk(2'd0, 12'h341, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h60, 1'b0, 32'h4, 32'h100, 32'h60, 1'b0, ST_IDLE));
    vecs.push_back(mk(2'd2, 12'h342, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h3, 1'b0, 32'h4, 32'h100, 32'h60, 1'b0, ST_IDLE));
    vecs.push_back(mk(2'd0, 12'h342, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h13, 1'b0, 32'h4, 32'h100, 32'h60, 1'b0, ST_IDLE));

    reset = 1'b1;
    drive(2'd0, 12'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset mie", bus.csr_mie_o, MIE_RST);
    chk("reset int_rst", 32'(bus.csr_int_rst_o), 32'h0);
    chk("reset trap", 32'(bus.csr_trap_o), 32'h0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    // Random read-modify-write traffic on mscratch against a reference model.
    ms = 32'hA5A5;
    for (int i = 0; i < 8; i++) begin
      op = 2'($urandom_range(1, 3));
      wd = $urandom;
      case (op)
        2'd1:    nxt = wd;
        2'd2:    nxt = ms | wd;
        default: nxt = ms & ~wd;
      endcase
      apply(mk(op, 12'h340, wd, 32'h0, 1'b0, 1'b0, 32'h0, ms, 1'b0,
               32'h4, 32'h100, 32'h60, 1'b0, ST_IDLE), 100 + i);
      ms = nxt;
    end
    apply(mk(2'd0, 12'h340, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, ms, 1'b0,
             32'h4, 32'h100, 32'h60, 1'b0, ST_IDLE), 200);

    // Async reset in the middle of HANDLER, with strobe and mret both pending.
    @(negedge clk);
    drive(2'd0, 12'h341, 32'h0, 32'h44, 1'b0, 1'b1, 32'h2);
    @(posedge clk);
    #1;
    chk("pre-reset state", 32'(bus.csr_state_o), 32'(ST_HANDLER));
    chk("pre-reset mepc", bus.csr_mepc_o, 32'h44);
    bus.csr_mret_i = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    chk("async mepc", bus.csr_mepc_o, 32'h0);
    chk("async mie", bus.csr_mie_o, MIE_RST);
    chk("async mtvec", bus.csr_mtvec_o, MTVEC_RST);
    chk("async state", 32'(bus.csr_state_o), 32'(ST_IDLE));
    chk("async trap", 32'(bus.csr_trap_o), 32'h0);
    chk("async rd", bus.csr_rd_o, 32'h0);
    pulses = 0;
    @(posedge clk);
    #1;
    if (bus.csr_int_rst_o) pulses++;
    @(negedge clk);
    reset = 1'b0;
    bus.csr_int_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      if (bus.csr_int_rst_o) pulses++;
      bus.csr_mret_i = 1'b0;
    end
    chk("post-reset pulses", 32'(pulses), 32'h0);
    chk("post-reset state", 32'(bus.csr_state_o), 32'(ST_IDLE));
    chk("post-reset mie", bus.csr_mie_o, MIE_RST);
    chk("post-reset queue", 32'(exp_q.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
